// File: rtl/sap_io_pkg.sv
// Shared types and helpers for the SAP-2 pad-side I/O bridge.
package sap_io_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sap_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin. With EDGE set, q is a
// one-cycle pulse on the synchronised rising edge; otherwise q is the level.
module sap_sync_edge #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q
);

    logic s1;
    logic s2;

    // Metastability chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic s3;

            // Delayed copy used to detect the rising edge.
            always_ff @(posedge clk) begin
                if (rst) s3 <= 1'b0;
                else     s3 <= s2;
            end

            assign q = s2 & ~s3;
        end else begin : g_level
            assign q = s2;
        end
    endgenerate

endmodule

// File: rtl/sap_io_bridge.sv
// Pad-side I/O bridge for the SAP-2 core: latched output channels with a
// display tap, a strobed input buffer with ready/overrun, and a program
// loader that holds the core in reset while streaming bytes into memory.
module sap_io_bridge
    import sap_io_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_OUT     = 4,
    parameter int ADDR_W      = 8,
    parameter int RELEASE_CYC = 4,
    localparam int PORT_W     = idx_w(NUM_OUT)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_stb,
    input  logic              ext_load,
    input  logic              cpu_out_we,
    input  logic [PORT_W-1:0] cpu_out_port,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_in_rd,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_ready,
    output logic              in_overrun,
    input  logic [PORT_W-1:0] disp_sel,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              load_busy
);

    localparam int                CNT_W    = idx_w(RELEASE_CYC);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RELEASE_CYC - 1);

    logic              stb_edge;
    logic              load_lvl;
    state_t            state;
    logic [CNT_W-1:0]  rel_cnt;
    logic [DATA_W-1:0] ch [NUM_OUT];

    sap_sync_edge #(.EDGE(1'b1)) u_stb_sync (
        .clk (CLK),
        .rst (RST),
        .din (ext_stb),
        .q   (stb_edge)
    );

    sap_sync_edge #(.EDGE(1'b0)) u_load_sync (
        .clk (CLK),
        .rst (RST),
        .din (ext_load),
        .q   (load_lvl)
    );

    // Mode FSM with loader datapath; cpu_rst and load_busy follow the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RELEASE;
            rel_cnt   <= CNT_INIT;
            cpu_rst   <= 1'b1;
            load_busy <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            // Address advances the cycle after each write pulse, so a write
            // issued on the LOAD exit edge still bumps it while in RELEASE.
            if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
            case (state)
                RUN: begin
                    if (load_lvl) begin
                        state     <= LOAD;
                        mem_addr  <= '0;
                        cpu_rst   <= 1'b1;
                        load_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (stb_edge) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= ext_data;
                    end
                    if (!load_lvl) begin
                        state     <= RELEASE;
                        rel_cnt   <= CNT_INIT;
                        load_busy <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (load_lvl) begin
                        state     <= LOAD;
                        mem_addr  <= '0;
                        load_busy <= 1'b1;
                    end else if (rel_cnt == '0) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= RELEASE;
                    rel_cnt   <= CNT_INIT;
                    cpu_rst   <= 1'b1;
                    load_busy <= 1'b0;
                end
            endcase
        end
    end

    // Input buffer handshake, live only while the core runs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cpu_in_data  <= '0;
            cpu_in_ready <= 1'b0;
            in_overrun   <= 1'b0;
        end else if (state == RUN) begin
            if (stb_edge) begin
                cpu_in_data  <= ext_data;
                cpu_in_ready <= 1'b1;
                if (cpu_in_ready && !cpu_in_rd) in_overrun <= 1'b1;
            end else if (cpu_in_rd) begin
                cpu_in_ready <= 1'b0;
            end
        end
    end

    // Output channel registers and the display write strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_OUT; i++) ch[i] <= '0;
            disp_stb <= 1'b0;
        end else begin
            disp_stb <= 1'b0;
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                if (cpu_out_we && cpu_out_port == PORT_W'(i)) begin
                    ch[i] <= cpu_out_data;
                    if (disp_sel == PORT_W'(i)) disp_stb <= 1'b1;
                end
            end
        end
    end

    // Display mux; an index with no channel reads as zero.
    always_comb begin
        disp_data = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (disp_sel == PORT_W'(i)) disp_data = ch[i];
        end
    end

endmodule
